// File: rtl/crc_pkg.sv
// Shared types, named generator polynomials and bit-reversal helper for the CRC stream engine.
package crc_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [4:0]  CRC5_USB    = 5'h05;
  localparam logic [7:0]  CRC8        = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;

  // Reverses the low w bits of x; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x,
                                                   input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational next-CRC for one DATA_W-bit word, Galois form, data MSB processed first.
module crc_step #(
  parameter int unsigned          DATA_W = 4,
  parameter int unsigned          CRC_W  = 5,
  parameter logic [CRC_W-1:0]     POLY   = CRC_W'(5'h05)
) (
  input  logic [CRC_W-1:0]  crc,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_next
);

  always_comb begin
    logic [CRC_W-1:0] c;
    logic             fb;
    c  = crc;
    fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine with framed valid/ready input and registered result handshake.
// Build option: define CRC_REFLECT_EN for LSB-first input and bit-reversed CRC output.
module crc_stream
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W  = 4,
  parameter int unsigned      CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC5_USB),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic [CNT_W-1:0]  word_cnt
);

  state_t              state, state_next;
  logic [CRC_W-1:0]    crc_reg, crc_reg_next;
  logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
  logic [CRC_W-1:0]    crc_out_next;
  logic [CNT_W-1:0]    word_cnt_next;
  logic                out_valid_next, in_ready_next;
  logic                accept;
  logic [CRC_W-1:0]    step_in, step_out;
  logic [DATA_W-1:0]   step_data;

  function automatic logic [CRC_W-1:0] fmt_out(input logic [CRC_W-1:0] c);
`ifdef CRC_REFLECT_EN
    return CRC_W'(bit_reverse(MAX_W'(c), CRC_W)) ^ XOR_OUT;
`else
    return c ^ XOR_OUT;
`endif
  endfunction

`ifdef CRC_REFLECT_EN
  assign step_data = DATA_W'(bit_reverse(MAX_W'(data_in), DATA_W));
`else
  assign step_data = data_in;
`endif

  // A new frame always starts from INIT, whatever crc_reg still holds.
  assign step_in = (state == IDLE) ? INIT : crc_reg;
  assign accept  = in_valid && in_ready;
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_step (
    .crc      (step_in),
    .data     (step_data),
    .crc_next (step_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    crc_reg_next   = crc_reg;
    cnt_next       = cnt;
    crc_out_next   = crc_out;
    word_cnt_next  = word_cnt;
    out_valid_next = 1'b0;
    in_ready_next  = 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          crc_reg_next = step_out;
          cnt_next     = CNT_W'(1);
          state_next   = in_last ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          crc_reg_next = step_out;
          cnt_next     = cnt_inc;
          if (in_last) state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next   = IDLE;
          crc_reg_next = INIT;
          cnt_next     = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        crc_reg_next = INIT;
        cnt_next     = '0;
      end
    endcase

    // Result is captured once, on the last word, so it stays put under backpressure.
    if (state != DONE && state_next == DONE) begin
      crc_out_next  = fmt_out(step_out);
      word_cnt_next = cnt_next;
    end

    if (abort) begin
      state_next    = IDLE;
      crc_reg_next  = INIT;
      cnt_next      = '0;
      crc_out_next  = crc_out;
      word_cnt_next = word_cnt;
    end

    out_valid_next = (state_next == DONE);
    in_ready_next  = (state_next != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_reg   <= INIT;
      cnt       <= '0;
      crc_out   <= fmt_out(INIT);
      word_cnt  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      crc_reg   <= crc_reg_next;
      cnt       <= cnt_next;
      crc_out   <= crc_out_next;
      word_cnt  <= word_cnt_next;
      out_valid <= out_valid_next;
      in_ready  <= in_ready_next;
    end
  end

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: frame table through a result scoreboard plus handshake/abort/reset sequences.
module tb_crc_stream;

`ifdef CRC_REFLECT_EN
  localparam bit REFLECT = 1'b1;
`else
  localparam bit REFLECT = 1'b0;
`endif

  typedef struct packed {
    int               n;
    logic [7:0][3:0]  w;
    int               gap;
    logic [4:0]       exp_crc;
    logic [15:0]      exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [4:0]  crc;
    logic [15:0] cnt;
  } exp_t;

  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  data_in;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  crc_out;
  logic [15:0] word_cnt;
  logic        in_ready_sat;
  logic        out_valid_sat;
  logic [4:0]  crc_out_sat;
  logic [1:0]  word_cnt_sat;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t ex;

  always #5 clk = ~clk;

  crc_stream dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .crc_out   (crc_out),
    .word_cnt  (word_cnt)
  );

  crc_stream #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready_sat),
    .data_in   (data_in),
    .in_last   (in_last),
    .out_valid (out_valid_sat),
    .out_ready (out_ready),
    .crc_out   (crc_out_sat),
    .word_cnt  (word_cnt_sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC over the first n words of a frame.
  function automatic logic [4:0] ref_crc(input logic [7:0][3:0] w, input int n);
    logic [4:0] c;
    logic [4:0] r;
    logic       b, fb;
    c = 5'h00;
    r = 5'h00;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        b  = REFLECT ? w[k][j] : w[k][3-j];
        fb = c[4] ^ b;
        c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
    end
    if (REFLECT) begin
      for (int j = 0; j < 5; j++) r[j] = c[4-j];
      c = r;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] d, input logic last);
    int   budget;
    logic taken;
    budget   = 0;
    taken    = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    in_last  = last;
    while (!taken && budget < 50) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_word: word %0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic send_frame(input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      if (k > 0) repeat (v.gap) tick();
      if (k == v.n - 1) sb.push_back('{crc: v.exp_crc, cnt: v.exp_cnt});
      send_word(v.w[k], k == v.n - 1);
    end
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while (sb.size() > 0 && b < 100) begin
      tick();
      b++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every result handshake must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: crc %0h cnt %0h with no frame outstanding", crc_out, word_cnt);
      end else begin
        e = sb.pop_front();
        check("res_crc", 32'(crc_out), 32'(e.crc));
        check("res_cnt", 32'(word_cnt), 32'(e.cnt));
        check("sat_valid", 32'(out_valid_sat), 32'd1);
        check("sat_crc", 32'(crc_out_sat), 32'(e.crc));
        check("sat_cnt", 32'(word_cnt_sat), (e.cnt > 16'd3) ? 32'd3 : 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NV; i++) begin
      vecs[i].n   = 1;
      vecs[i].w   = '0;
      vecs[i].gap = 0;
    end
    vecs[0].w[0] = 4'h2;
    vecs[1].n = 2; vecs[1].w[0] = 4'h2; vecs[1].w[1] = 4'h2;
    vecs[2].w[0] = 4'hF;
    vecs[3].n = 2; vecs[3].w[0] = 4'h2; vecs[3].w[1] = 4'h2; vecs[3].gap = 2;
    vecs[4].w[0] = 4'h4;
    vecs[5].n = 5;
    vecs[6].n = 7; vecs[6].gap = 1;
    vecs[7].n = 3;
    for (int i = 5; i < NV; i++)
      for (int k = 0; k < 8; k++) vecs[i].w[k] = 4'($urandom);
    for (int i = 0; i < NV; i++) begin
      vecs[i].exp_cnt = 16'(vecs[i].n);
      vecs[i].exp_crc = ref_crc(vecs[i].w, vecs[i].n);
    end
    if (!REFLECT) begin
      vecs[0].exp_crc = 5'h0A;
      vecs[1].exp_crc = 5'h1B;
      vecs[2].exp_crc = 5'h16;
      vecs[3].exp_crc = 5'h1B;
      vecs[4].exp_crc = 5'h14;
    end else begin
      vecs[4].exp_crc = 5'h0A;
    end

    reset     = 1'b1;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    data_in   = 4'h0;
    out_ready = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_crc_out", 32'(crc_out), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_in_ready_sat", 32'(in_ready_sat), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);

    // Table frames back-to-back through the scoreboard.
    for (int i = 0; i < NV; i++) send_frame(vecs[i]);
    drain("drain_table");

    // Result backpressure holds crc_out/word_cnt and blocks input.
    out_ready = 1'b0;
    send_frame(vecs[1]);
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_crc_out", 32'(crc_out), 32'(vecs[1].exp_crc));
      check("bp_word_cnt", 32'(word_cnt), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("drain_bp");

    // Abort in RUN discards the partial frame and the word offered with it.
    send_word(4'h2, 1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    data_in  = 4'hF;
    in_last  = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("abort_run_out_valid", 32'(out_valid), 32'd0);
    send_frame(vecs[0]);
    drain("drain_abort_run");

    // Abort in DONE drops the pending result without a handshake.
    out_ready = 1'b0;
    send_frame(vecs[2]);
    @(negedge clk);
    check("abort_done_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_done_out_valid", 32'(out_valid), 32'd0);
    check("abort_done_in_ready", 32'(in_ready), 32'd1);
    ex = sb.pop_back();
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset while a result is pending.
    out_ready = 1'b0;
    send_frame(vecs[0]);
    #1;
    check("rst_done_pre_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_done_out_valid", 32'(out_valid), 32'd0);
    check("rst_done_crc_out", 32'(crc_out), 32'd0);
    check("rst_done_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_done_sat_valid", 32'(out_valid_sat), 32'd0);
    ex = sb.pop_back();
    @(posedge clk);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    tick();

    // Asynchronous reset mid-frame, then a clean single-word frame.
    send_word(4'hF, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    tick();
    send_frame(vecs[0]);
    drain("drain_rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
